// File: rtl/univ_shift_reg_if.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_if
// Groups the control, serial and parallel signals of the universal shift
// register. clk and rst are not part of the bundle; they stay plain ports.
//
//   mode       2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   si_r       1      serial in for right shift (enters MSB)
//   si_l       1      serial in for left shift (enters LSB)
//   pi         WIDTH  parallel load data
//   po         WIDTH  registered register contents
//   so_r       1      serial out, right direction (po[0])
//   so_l       1      serial out, left direction (po[WIDTH-1])
//   shift_cnt  CNT_W  shifts completed in the current word, 0..WIDTH-1
//   word_done  1      one-cycle pulse after the WIDTH-th shift of a word
//
// master : the side that drives mode/serial/parallel inputs (upstream logic)
// slave  : the shift register itself
// -----------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [1:0]       mode;
    logic             si_r;
    logic             si_l;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] po;
    logic             so_r;
    logic             so_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    modport master (
        output mode, si_r, si_l, pi,
        input  po, so_r, so_l, shift_cnt, word_done
    );

    modport slave (
        input  mode, si_r, si_l, pi,
        output po, so_r, so_l, shift_cnt, word_done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, serial I/O at both ends. A shift counter frames WIDTH-bit
// words and produces a registered one-cycle word_done pulse when the WIDTH-th
// shift of a word completes. Left and right shifts count together.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high (overrides mode)
//   bus   slave modport of univ_shift_reg_if (mode, si_r, si_l, pi,
//         po, so_r, so_l, shift_cnt, word_done)
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    univ_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_po;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_po_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_done_next;

    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [CNT_W-1:0] w_cnt_adv;
    logic             w_cnt_wrap;

    // Shifted images of the register, one bit slice per position.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign w_shr[gi] = bus.si_r;
            end else begin : g_not_msb
                assign w_shr[gi] = r_po[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign w_shl[gi] = bus.si_l;
            end else begin : g_not_lsb
                assign w_shl[gi] = r_po[gi-1];
            end
        end
    endgenerate

    // Counter advance shared by both shift directions; wrapping at the last
    // position closes the word and raises word_done for the next cycle.
    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_cnt_adv  = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);

    always_comb begin
        w_po_next   = r_po;
        w_cnt_next  = r_cnt;
        w_done_next = 1'b0;
        case (mode_e'(bus.mode))
            MODE_HOLD: begin
                w_po_next  = r_po;
                w_cnt_next = r_cnt;
            end
            MODE_SHR: begin
                w_po_next   = w_shr;
                w_cnt_next  = w_cnt_adv;
                w_done_next = w_cnt_wrap;
            end
            MODE_SHL: begin
                w_po_next   = w_shl;
                w_cnt_next  = w_cnt_adv;
                w_done_next = w_cnt_wrap;
            end
            MODE_LOAD: begin
                // A load starts a fresh word.
                w_po_next  = bus.pi;
                w_cnt_next = '0;
            end
            default: begin
                w_po_next  = r_po;
                w_cnt_next = r_cnt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_po   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_po   <= w_po_next;
            r_cnt  <= w_cnt_next;
            r_done <= w_done_next;
        end
    end

    assign bus.po        = r_po;
    assign bus.so_r      = r_po[0];
    assign bus.so_l      = r_po[WIDTH-1];
    assign bus.shift_cnt = r_cnt;
    assign bus.word_done = r_done;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 8-bit serial-in/parallel-out register. Supports hold, shift right, shift left and parallel load, with serial I/O at both ends. Adds a shift counter and a one-cycle word-complete pulse, so an upstream serialiser/deserialiser can frame WIDTH-bit words without external counting. Single clock domain; used in serial links and test scan paths.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, width of shift counter output (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
si_r  in  1  serial in for right shift, enters MSB
si_l  in  1  serial in for left shift, enters LSB
pi  in  WIDTH  parallel load data
po  out  WIDTH  register contents (registered)
so_r  out  1  serial out, right direction = po[0]
so_l  out  1  serial out, left direction = po[WIDTH-1]
shift_cnt  out  CNT_W  shifts completed in current word, 0..WIDTH-1
word_done  out  1  one-cycle pulse, registered, when WIDTH-th shift of a word completes

Behaviour:
- Reset: on rising clk with rst=1: po=0, shift_cnt=0, word_done=0. rst overrides mode. Reset mid-word discards the partial word; no word_done.
- All state updates on rising clk only; no combinational path from inputs to outputs. so_r/so_l are direct taps of po.
- mode 00 hold: po, shift_cnt unchanged; word_done=0.
- mode 01 shift right: po <= {si_r, po[WIDTH-1:1]}. Bit leaving on so_r is po[0] before the edge.
- mode 10 shift left: po <= {po[WIDTH-2:0], si_l}. Bit leaving on so_l is po[WIDTH-1] before the edge.
- mode 11 load: po <= pi; shift_cnt <= 0; word_done <= 0. Load starts a new word.
- Counter, modes 01/10 (direction-agnostic, mixed directions count together):
  - shift_cnt < WIDTH-1: shift_cnt <= shift_cnt+1; word_done <= 0.
  - shift_cnt == WIDTH-1: shift_cnt <= 0; word_done <= 1 in the following cycle (registered with the shift).
- word_done is high exactly one cycle per completed word; back-to-back words give pulses WIDTH cycles apart with continuous shifting.
- Hold cycles pause the counter; a word may be spread across any number of hold cycles.
- After WIDTH consecutive right shifts from any state, po equals the last WIDTH si_r bits, first bit in po[0].
- Mode values beyond the four listed do not exist (2-bit field fully decoded).

Test Plan:
- WIDTH=8; rst=1 for 2 cycles with mode=11, pi=8'hFF -> po=8'h00, shift_cnt=0, word_done=0 (reset wins over load).
- Load pi=8'hA5, then 8 right shifts with si_r=0 -> so_r sequence 1,0,1,0,0,1,0,1; po=8'h00 after; word_done high only in cycle after 8th shift; shift_cnt 1..7 then 0.
- From reset, 8 left shifts with si_l sequence 1,1,0,0,1,0,1,1 -> po=8'hCB, so_l shows prior MSBs; word_done one pulse.
- Shift right 3, hold 5 cycles, shift left 5 -> shift_cnt stays 3 during hold; word_done pulses after 8th shift total.
- 4 shifts then load 8'h3C -> shift_cnt=0, po=8'h3C, no word_done; next 8 shifts produce exactly one pulse.
- Continuous right shifting 24 cycles -> word_done pulses at cycles 8, 16, 24 (1-cycle each); rst asserted at cycle 20 -> all cleared, no pulse at 24.
